// File: rtl/dcache_fill_fsm_if.sv
// Bundle between the data-cache miss controller, the cache arrays and main memory.
// The controller takes the slave side; the cache/memory environment takes the master side.
interface dcache_fill_fsm_if #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;
    logic              write_data_array;
    logic [OFF_W-1:0]  fill_word_offset;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;

    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_read_en, memory_address,
               write_data_array, fill_word_offset, fill_data, write_tag_array
    );

    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_read_en, memory_address,
               write_data_array, fill_word_offset, fill_data, write_tag_array
    );
endinterface

// File: rtl/dcache_fill_fsm.sv
// Data-cache miss controller: stalls the pipeline, streams one block in from
// pipelined main memory a word per request, and writes the data and tag arrays.
module dcache_fill_fsm #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dcache_fill_fsm_if.slave bus
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    // Byte-address bits covered by one block (word offset plus the byte-in-word bit).
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << (OFF_W + 1)) - 1);
    localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [OFF_W:0]    req_cnt;
    logic [OFF_W-1:0]  rcv_cnt;
    logic              inFill;
    logic              reqActive;
    logic              rspActive;
    logic              lastRsp;

    always_comb begin
        // Gating with rst_n keeps every output quiet while reset is held.
        inFill    = rst_n && (state == FILL);
        reqActive = inFill && !req_cnt[OFF_W];
        rspActive = inFill && bus.memory_data_valid;
        lastRsp   = rspActive && (rcv_cnt == LAST_WORD);

        bus.fsm_busy         = rst_n && ((state == FILL) || bus.miss_detected);
        bus.mem_read_en      = reqActive;
        bus.memory_address   = reqActive ? (base + ADDR_W'({req_cnt[OFF_W-1:0], 1'b0}))
                                         : {ADDR_W{1'b0}};
        bus.write_data_array = rspActive;
        bus.fill_word_offset = rspActive ? rcv_cnt : {OFF_W{1'b0}};
        bus.fill_data        = rspActive ? bus.memory_data : {DATA_W{1'b0}};
        bus.write_tag_array  = lastRsp;
    end

    // base is not reset: it is only observed while in FILL, after a miss has loaded it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_cnt <= '0;
            rcv_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base    <= bus.miss_address & ~OFF_MASK;
                        req_cnt <= '0;
                        rcv_cnt <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (reqActive) req_cnt <= req_cnt + 1'b1;
                    if (rspActive) rcv_cnt <= rcv_cnt + 1'b1;
                    if (lastRsp)   state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Bench for dcache_fill_fsm: a vector table for reset and a basic fill, then
// scoreboard-checked sequences for wrap, held miss, irregular memory and mid-fill reset.
module tb_dcache_fill_fsm;
    logic clk;
    logic rst_n;

    dcache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) bus ();

    dcache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] missAddr;
        logic        valid;
        logic [15:0] data;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        wr;
        logic [2:0]  off;
        logic [15:0] wdata;
        logic        tag;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } memReq_t;

    typedef struct {
        logic [2:0]  off;
        logic [15:0] data;
        logic        tag;
    } sbEnt_t;

    vec_t        vecs[16];
    memReq_t     memQ[$];
    sbEnt_t      sbQ[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc;
    int          reqIdx;
    logic        rstIn;
    logic        missIn;
    logic [15:0] missAddrIn;
    logic [15:0] expBase;
    bit          fixedLat;
    logic [63:0] busyMask, rdMask, tagMask, extraValid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // One clock of the scoreboarded environment: memory model drives returns,
    // requests push expected writes, writes pop and compare.
    task automatic runCycle();
        logic        hit;
        logic [15:0] expAddr;
        memReq_t     m;
        sbEnt_t      e;
        rst_n                 = rstIn;
        bus.miss_detected     = missIn;
        bus.miss_address      = missAddrIn;
        hit                   = fixedLat && (memQ.size() > 0) && (memQ[0].due == cyc);
        bus.memory_data_valid = hit || extraValid[cyc];
        bus.memory_data       = 16'h0000;
        if (bus.memory_data_valid) begin
            if (memQ.size() > 0) begin
                m = memQ.pop_front();
                bus.memory_data = m.addr ^ 16'hA5A5;
            end else begin
                bus.memory_data = 16'hDEAD;
            end
        end
        @(negedge clk);
        check("busy", bus.fsm_busy, busyMask[cyc]);
        check("rdEn", bus.mem_read_en, rdMask[cyc]);
        check("tagWr", bus.write_tag_array, tagMask[cyc]);
        if (!rstIn) check("rstDataWr", bus.write_data_array, 1'b0);
        if (bus.mem_read_en) begin
            expAddr = expBase + 16'(2 * reqIdx);
            check("reqAddr", bus.memory_address, expAddr);
            m.due  = cyc + 4;
            m.addr = expAddr;
            memQ.push_back(m);
            e.off  = 3'(reqIdx);
            e.data = expAddr ^ 16'hA5A5;
            e.tag  = (reqIdx == 7);
            sbQ.push_back(e);
            reqIdx++;
        end else begin
            check("idleAddr", bus.memory_address, 16'h0000);
        end
        if (bus.write_data_array) begin
            if (sbQ.size() == 0) begin
                check("strayWrite", bus.write_data_array, 1'b0);
            end else begin
                e = sbQ.pop_front();
                check("fillOff", bus.fill_word_offset, e.off);
                check("fillData", bus.fill_data, e.data);
                check("lastTag", bus.write_tag_array, e.tag);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resetBetween();
        memQ.delete();
        sbQ.delete();
        busyMask   = '0;
        rdMask     = '0;
        tagMask    = '0;
        extraValid = '0;
        fixedLat   = 1'b1;
        rstIn      = 1'b0;
        missIn     = 1'b1;
        missAddrIn = 16'h7777;
        cyc        = 0;
        reqIdx     = 0;
        repeat (2) runCycle();
        rstIn  = 1'b1;
        missIn = 1'b0;
        cyc    = 0;
    endtask

    task automatic endCheck();
        check("sbDrained", sbQ.size(), 0);
        check("reqCount", reqIdx, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst_n                 = 1'b0;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0000;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0000;

        // Rows 0-1: reset held with a miss; rows 2-15: miss at 0x1236 in cycle c=0.
        for (int k = 0; k < 16; k++) begin
            c = k - 2;
            vecs[k].rst      = (k >= 2);
            vecs[k].miss     = (k < 2) || (c == 0);
            vecs[k].missAddr = 16'h1236;
            vecs[k].valid    = (c >= 5) && (c <= 12);
            vecs[k].data     = vecs[k].valid ? ((16'h1230 + 16'(2 * (c - 5))) ^ 16'hA5A5) : 16'h0;
            vecs[k].busy     = (c >= 0) && (c <= 12);
            vecs[k].rd       = (c >= 1) && (c <= 8);
            vecs[k].addr     = vecs[k].rd ? (16'h1230 + 16'(2 * (c - 1))) : 16'h0;
            vecs[k].wr       = vecs[k].valid;
            vecs[k].off      = 3'(c - 5);
            vecs[k].wdata    = vecs[k].data;
            vecs[k].tag      = (c == 12);
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            cyc                   = k;
            rst_n                 = vecs[k].rst;
            bus.miss_detected     = vecs[k].miss;
            bus.miss_address      = vecs[k].missAddr;
            bus.memory_data_valid = vecs[k].valid;
            bus.memory_data       = vecs[k].data;
            @(negedge clk);
            check("vBusy", bus.fsm_busy, vecs[k].busy);
            check("vRdEn", bus.mem_read_en, vecs[k].rd);
            check("vAddr", bus.memory_address, vecs[k].addr);
            check("vWr", bus.write_data_array, vecs[k].wr);
            check("vTag", bus.write_tag_array, vecs[k].tag);
            if (vecs[k].wr) begin
                check("vOff", bus.fill_word_offset, vecs[k].off);
                check("vData", bus.fill_data, vecs[k].wdata);
            end
            @(posedge clk);
            #1;
        end

        // Miss at the top of the address space: block must not wrap.
        resetBetween();
        expBase  = 16'hFFF0;
        busyMask = rng(0, 12);
        rdMask   = rng(1, 8);
        tagMask  = rng(12, 12);
        for (int i = 0; i < 15; i++) begin
            missIn     = (i == 0);
            missAddrIn = 16'hFFFE;
            runCycle();
        end
        endCheck();

        // Miss held high across completion, address changing mid-fill.
        resetBetween();
        expBase  = 16'h1230;
        busyMask = rng(0, 25);
        rdMask   = rng(1, 8) | rng(14, 21);
        tagMask  = rng(12, 12) | rng(25, 25);
        for (int i = 0; i < 28; i++) begin
            missIn     = (i <= 14);
            missAddrIn = (i < 3) ? 16'h1236 : 16'h0400;
            if (i == 14) begin
                check("firstFillReqs", reqIdx, 8);
                expBase = 16'h0400;
                reqIdx  = 0;
            end
            runCycle();
        end
        endCheck();

        // Irregular memory return timing.
        resetBetween();
        expBase    = 16'h3450;
        fixedLat   = 1'b0;
        extraValid = rng(5, 5) | rng(9, 10) | rng(20, 22) | rng(30, 31);
        busyMask   = rng(0, 31);
        rdMask     = rng(1, 8);
        tagMask    = rng(31, 31);
        for (int i = 0; i < 34; i++) begin
            missIn     = (i == 0);
            missAddrIn = 16'h3458;
            runCycle();
        end
        endCheck();

        // Reset in cycle 6 of a fill, stray returns afterwards, then a clean fill.
        resetBetween();
        expBase    = 16'h5670;
        extraValid = rng(7, 12);
        busyMask   = rng(0, 5) | rng(14, 26);
        rdMask     = rng(1, 5) | rng(15, 22);
        tagMask    = rng(26, 26);
        for (int i = 0; i < 29; i++) begin
            rstIn      = (i != 6);
            missIn     = (i == 0) || (i == 14);
            missAddrIn = (i == 0) ? 16'h5678 : 16'h2000;
            if (i == 6) sbQ.delete();
            if (i == 14) begin
                expBase = 16'h2000;
                reqIdx  = 0;
            end
            runCycle();
        end
        endCheck();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
